// File: rtl/pwm_stream_tx_pkg.sv
// Shared definitions for the multi-channel PWM stream transmitter.
//   state_t  : playback FSM encoding
//   idx_bits : width of a slot index for n channels (at least 1 bit)
package pwm_stream_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// First-word-fall-through frame FIFO, depth 2^AW.
//   clk, rst     : clock, async active-low reset
//   push, wdata  : write request; ignored while full (even with a concurrent pop)
//   pop          : consume head word; ignored while empty
//   rdata        : head word, valid whenever !empty
//   full, empty  : status, derived from the registered level
//   level        : exact number of stored words (AW+1 bits)
module frame_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // storage carries no reset: contents are only observable once pushed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pwm_stream_tx.sv
// Multi-channel PWM transmitter fed by a byte stream.
//   clk, rst        : clock, async active-low reset
//   s_data/valid/ready : interleaved sample bytes, ch0 first in each frame
//   enable          : playback allowed
//   clr_underrun    : clears the sticky underrun flag
//   pwm             : one registered PWM output per channel
//   nsync           : low during step 0 of each period
//   bclk            : high on the first clk of every step
//   underrun        : a period boundary found the FIFO empty
//   fifo_level      : frames currently buffered
module pwm_stream_tx
  import pwm_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNELS      = 2,
  parameter int FIFO_AW       = 8,
  parameter int CLKS_PER_STEP = 1,
  parameter int UNDERRUN_MID  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  enable,
  input  logic                  clr_underrun,
  output logic [CHANNELS-1:0]   pwm,
  output logic                  nsync,
  output logic                  bclk,
  output logic                  underrun,
  output logic [FIFO_AW:0]      fifo_level
);
  localparam int W  = DATA_WIDTH;
  localparam int IW = idx_bits(CHANNELS);
  localparam int PW = $clog2(CLKS_PER_STEP + 1);

  localparam logic [W-1:0]  LAST_STEP = W'((1 << W) - 2);
  localparam logic [W-1:0]  MID       = W'(1 << (W - 1));
  localparam logic [PW-1:0] PS_LAST   = PW'(CLKS_PER_STEP - 1);
  localparam logic [IW-1:0] LAST_SLOT = IW'(CHANNELS - 1);

  typedef logic [CHANNELS-1:0][W-1:0] frame_t;

  // ---------------- packer ----------------
  logic [IW-1:0] idx;
  frame_t        pack_buf, push_frame;
  logic          hold, live, xfer, last_slot;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  frame_t        fifo_rdata;

  // live gives the one-clk s_ready=0 window right after reset release
  assign s_ready   = live & ~hold;
  assign xfer      = s_valid & s_ready;
  assign last_slot = (idx == LAST_SLOT);
  assign fifo_push = hold | (xfer & last_slot);

  // completing byte goes straight into the pushed frame; a held frame is already whole
  always_comb begin
    push_frame = pack_buf;
    if (!hold) push_frame[idx] = s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      pack_buf <= '0;
      hold     <= 1'b0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (xfer) begin
        pack_buf[idx] <= s_data;
        idx           <= last_slot ? '0 : idx + 1'b1;
        if (last_slot && fifo_full) hold <= 1'b1;
      end
      if (hold && !fifo_full) hold <= 1'b0;
    end
  end

  frame_fifo #(
    .WIDTH(CHANNELS * W),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(push_frame),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  // ---------------- playback ----------------
  state_t             state, state_n;
  logic [W-1:0]       step, step_n;
  logic [PW-1:0]      presc, presc_n;
  frame_t             smp, smp_n;
  logic [CHANNELS-1:0] pwm_n;
  logic               nsync_n, bclk_n, urun_set;

  always_comb begin
    state_n  = state;
    step_n   = step;
    presc_n  = presc;
    smp_n    = smp;
    fifo_pop = 1'b0;
    urun_set = 1'b0;
    case (state)
      ST_IDLE: begin
        step_n  = '0;
        presc_n = '0;
        if (enable && !fifo_empty) begin
          state_n  = ST_RUN;
          fifo_pop = 1'b1;
          smp_n    = fifo_rdata;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_n = ST_IDLE;
          step_n  = '0;
          presc_n = '0;
        end else if (presc == PS_LAST) begin
          presc_n = '0;
          if (step == LAST_STEP) begin
            step_n = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              smp_n    = fifo_rdata;
            end else begin
              urun_set = 1'b1;
              if (UNDERRUN_MID != 0) smp_n = {CHANNELS{MID}};
            end
          end else begin
            step_n = step + 1'b1;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // outputs are registered from the next-state values so they line up with step
  always_comb begin
    pwm_n   = '0;
    nsync_n = 1'b1;
    bclk_n  = 1'b0;
    if (state_n == ST_RUN) begin
      for (int i = 0; i < CHANNELS; i++) pwm_n[i] = (step_n < smp_n[i]);
      nsync_n = (step_n != '0);
      bclk_n  = (presc_n == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      step     <= '0;
      presc    <= '0;
      smp      <= '0;
      pwm      <= '0;
      nsync    <= 1'b1;
      bclk     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      presc    <= presc_n;
      smp      <= smp_n;
      pwm      <= pwm_n;
      nsync    <= nsync_n;
      bclk     <= bclk_n;
      underrun <= urun_set | (underrun & ~clr_underrun);
    end
  end

endmodule

// File: tb/tb_pwm_stream_tx.sv
// Bench for pwm_stream_tx: three instances (repeat-on-underrun, mid-scale-on-underrun,
// 3 clks per step). Expected per-period high times are queued as frames are sent and
// popped when the DUT plays a period.
module tb_pwm_stream_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [3];
  logic [7:0] sd    [3];
  logic       sv    [3];
  logic       en    [3];
  logic       clr   [3];
  logic       srdy  [3];
  logic [1:0] pwm   [3];
  logic       nsync [3];
  logic       bclk  [3];
  logic       urun  [3];
  logic [4:0] lvl   [3];

  pwm_stream_tx #(.FIFO_AW(4)) d0 (
    .clk(clk), .rst(rst_n[0]), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(srdy[0]),
    .enable(en[0]), .clr_underrun(clr[0]), .pwm(pwm[0]), .nsync(nsync[0]),
    .bclk(bclk[0]), .underrun(urun[0]), .fifo_level(lvl[0]));

  pwm_stream_tx #(.FIFO_AW(4), .UNDERRUN_MID(1)) d1 (
    .clk(clk), .rst(rst_n[1]), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(srdy[1]),
    .enable(en[1]), .clr_underrun(clr[1]), .pwm(pwm[1]), .nsync(nsync[1]),
    .bclk(bclk[1]), .underrun(urun[1]), .fifo_level(lvl[1]));

  pwm_stream_tx #(.FIFO_AW(4), .CLKS_PER_STEP(3)) d2 (
    .clk(clk), .rst(rst_n[2]), .s_data(sd[2]), .s_valid(sv[2]), .s_ready(srdy[2]),
    .enable(en[2]), .clr_underrun(clr[2]), .pwm(pwm[2]), .nsync(nsync[2]),
    .bclk(bclk[2]), .underrun(urun[2]), .fifo_level(lvl[2]));

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         e0;
    int         e1;
  } vec_t;

  typedef struct {
    int e0;
    int e1;
  } exp_t;

  vec_t tbl [4];
  exp_t q0[$], q1[$], q2[$];
  exp_t lastv [3];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input int k, input string nm);
    check({nm, " pwm"}, int'(pwm[k]), 0);
    check({nm, " nsync"}, int'(nsync[k]), 1);
    check({nm, " bclk"}, int'(bclk[k]), 0);
    check({nm, " s_ready"}, int'(srdy[k]), 0);
    check({nm, " underrun"}, int'(urun[k]), 0);
    check({nm, " level"}, int'(lvl[k]), 0);
  endtask

  // caller is away from a posedge; s_ready is registered so it is stable until the next one
  task automatic send_byte(input int k, input logic [7:0] b, output bit ok);
    sd[k] = b;
    sv[k] = 1'b1;
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (srdy[k]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    sv[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input vec_t v);
    bit   ok0, ok1;
    exp_t e;
    send_byte(k, v.b0, ok0);
    send_byte(k, v.b1, ok1);
    if (!(ok0 && ok1)) check("send accept", 0, 1);
    e.e0 = v.e0;
    e.e1 = v.e1;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // measures one full period starting at the first clk with nsync low
  task automatic check_period(input int k, input string nm);
    int   cps, hi0, hi1, len, bc, nl;
    bit   seen, have;
    exp_t e;
    cps  = (k == 2) ? 3 : 1;
    have = 1'b0;
    e.e0 = 0;
    e.e1 = 0;
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (have) lastv[k] = e;
    else if (k == 1) begin e.e0 = 128; e.e1 = 128; end
    else e = lastv[k];

    for (int w = 0; w < 3000 && nsync[k]; w++) @(negedge clk);
    check({nm, " period start"}, int'(nsync[k]), 0);
    hi0 = 0; hi1 = 0; len = 0; bc = 0; nl = 0; seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      hi0 += int'(pwm[k][0]);
      hi1 += int'(pwm[k][1]);
      bc  += int'(bclk[k]);
      nl  += int'(!nsync[k]);
      len++;
      @(negedge clk);
      if (!nsync[k]) begin
        if (seen) break;
      end else seen = 1'b1;
    end
    check({nm, " len"}, len, 255 * cps);
    check({nm, " hi0"}, hi0, e.e0 * cps);
    check({nm, " hi1"}, hi1, e.e1 * cps);
    check({nm, " bclk"}, bc, 255);
    check({nm, " nsync low"}, nl, cps);
  endtask

  initial begin
    bit ok;
    int wt;
    tbl[0] = '{8'h40, 8'hC0, 64, 192};
    tbl[1] = '{8'h00, 8'hFF, 0, 255};
    tbl[2] = '{8'h00, 8'hFF, 0, 255};
    tbl[3] = '{8'h80, 8'h01, 128, 1};
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; sd[k] = '0; sv[k] = 1'b0; en[k] = 1'b0; clr[k] = 1'b0;
      lastv[k].e0 = 0; lastv[k].e1 = 0;
    end

    // reset state and first-clk s_ready
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_reset(k, $sformatf("reset d%0d", k));
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    #1 check("s_ready before 1st clk", int'(srdy[0]), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("s_ready after release d%0d", k), int'(srdy[k]), 1);

    // duty table, full-scale extremes across the boundary, then underrun repeat
    for (int i = 0; i < 4; i++) send_frame(0, tbl[i]);
    check("level after 4 frames", int'(lvl[0]), 4);
    en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_period(0, $sformatf("vec%0d", i));
      if (i == 0) check("underrun clear while fed", int'(urun[0]), 0);
    end
    check("underrun set", int'(urun[0]), 1);
    check_period(0, "repeat last");
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    check("underrun cleared", int'(urun[0]), 0);
    en[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("idle pwm", int'(pwm[0]), 0);
    check("idle nsync", int'(nsync[0]), 1);
    check("idle bclk", int'(bclk[0]), 0);

    // fill to full with playback off, then back-pressure
    for (int b = 1; b <= 34; b++) begin
      send_byte(0, 8'(b), ok);
      if (!ok) check($sformatf("fill byte %0d accept", b), 0, 1);
      if (b == 2)  check("level 1 frame", int'(lvl[0]), 1);
      if (b == 32) check("level full", int'(lvl[0]), 16);
    end
    check("s_ready low after byte 34", int'(srdy[0]), 0);
    sd[0] = 8'd35;
    sv[0] = 1'b1;
    repeat (8) @(negedge clk);
    check("s_ready held low", int'(srdy[0]), 0);
    check("level held full", int'(lvl[0]), 16);
    en[0] = 1'b1;
    wt = 0;
    while (!srdy[0] && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check("s_ready returns", int'(srdy[0]), 1);
    check("s_ready return latency", wt, 2);
    check("level after pop+push", int'(lvl[0]), 16);
    @(posedge clk);
    #1 sv[0] = 1'b0;

    // async reset mid-period with a half-filled frame in the packer
    repeat (50) @(negedge clk);
    #3 rst_n[0] = 1'b0;
    #1 chk_reset(0, "async reset");
    @(negedge clk);
    rst_n[0] = 1'b1;
    en[0]    = 1'b0;
    q0.delete();
    @(posedge clk);
    #1 check("s_ready after 2nd release", int'(srdy[0]), 1);
    send_frame(0, '{8'h11, 8'h22, 17, 34});
    en[0] = 1'b1;
    check_period(0, "post-reset ch order");

    // mid-scale on underrun
    send_frame(1, tbl[0]);
    en[1] = 1'b1;
    check_period(1, "mid first");
    check_period(1, "mid underrun");
    check("mid underrun flag", int'(urun[1]), 1);

    // 3 clks per step
    send_frame(2, tbl[0]);
    send_frame(2, '{8'h20, 8'hE0, 32, 224});
    en[2] = 1'b1;
    check_period(2, "cps3 p0");
    check_period(2, "cps3 p1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
